comp2_arb: RTL and testbench

COMP2_ARB -- requirements
Module: comp2_arb

---
 rtl/comp2_arb_if.sv | 42 ++++
 rtl/comp2_arb.sv | 119 +++++++++++
 tb/tb_comp2_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/comp2_arb_if.sv
// Bundle between four requesters, the shared 2-bit comparator and the response consumer.
// No logic; the arbiter owns timing (grant combinational in IDLE, response registered).
// Backpressure: requests wait on req_ready, the response holds until rsp_ready.
interface comp2_arb_if;
    logic [3:0] req_valid;
    logic [7:0] req_x;
    logic [7:0] req_y;
    logic [3:0] req_ready;

    logic       cmp_x1;
    logic       cmp_x0;
    logic       cmp_y1;
    logic       cmp_y0;
    logic       cmp_zx;
    logic       cmp_zy;
    logic       cmp_zeq;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_id;
    logic       rsp_zx;
    logic       rsp_zy;
    logic       rsp_zeq;

    modport master (
        output req_valid, req_x, req_y,
        input  req_ready,
        input  cmp_x1, cmp_x0, cmp_y1, cmp_y0,
        output cmp_zx, cmp_zy, cmp_zeq,
        input  rsp_valid, rsp_id, rsp_zx, rsp_zy, rsp_zeq,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_x, req_y,
        output req_ready,
        output cmp_x1, cmp_x0, cmp_y1, cmp_y0,
        input  cmp_zx, cmp_zy, cmp_zeq,
        output rsp_valid, rsp_id, rsp_zx, rsp_zy, rsp_zeq,
        input  rsp_ready
    );
endinterface

// File: rtl/comp2_arb.sv
// Round-robin arbiter sharing one external 2-bit comparator among four requesters.
// Latency: response valid SETTLE edges after the grant edge (SETTLE legal 1..15).
// Backpressure: one transaction in flight; no grant until the response handshakes.
module comp2_arb #(
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    comp2_arb_if.slave   bus,
    output logic         busy,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] id_q;
    logic [3:0] cnt;
    logic [1:0] x_q;
    logic [1:0] y_q;
    logic       rsp_valid_q;
    logic       zx_q;
    logic       zy_q;
    logic       zeq_q;

    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic [1:0] idx;
    logic       gnt_any;
    logic [1:0] hot_cnt;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant   = 4'b0000;
        gnt_idx = ptr;
        idx     = ptr;
        gnt_any = 1'b0;
        if (state == IDLE) begin
            for (int k = 1; k <= 4; k++) begin
                idx = ptr + 2'(k);
                if (!gnt_any && bus.req_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        if (gnt_any)
            grant = 4'b0001 << gnt_idx;
    end

    assign hot_cnt = {1'b0, bus.cmp_zx} + {1'b0, bus.cmp_zy} + {1'b0, bus.cmp_zeq};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd3;
            id_q        <= 2'd0;
            cnt         <= 4'd0;
            x_q         <= 2'd0;
            y_q         <= 2'd0;
            rsp_valid_q <= 1'b0;
            zx_q        <= 1'b0;
            zy_q        <= 1'b0;
            zeq_q       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        x_q   <= bus.req_x[2*gnt_idx +: 2];
                        y_q   <= bus.req_y[2*gnt_idx +: 2];
                        id_q  <= gnt_idx;
                        ptr   <= gnt_idx;
                        cnt   <= 4'(SETTLE - 1);
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        zx_q        <= bus.cmp_zx;
                        zy_q        <= bus.cmp_zy;
                        zeq_q       <= bus.cmp_zeq;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                        // A broken comparator is flagged but its result still goes out as-is.
                        if (hot_cnt != 2'd1)
                            err <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.cmp_x1    = x_q[1];
    assign bus.cmp_x0    = x_q[0];
    assign bus.cmp_y1    = y_q[1];
    assign bus.cmp_y0    = y_q[0];
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_zx    = zx_q;
    assign bus.rsp_zy    = zy_q;
    assign bus.rsp_zeq   = zeq_q;
endmodule

// File: tb/tb_comp2_arb.sv
// Directed bench for comp2_arb with a behavioural 2-bit comparator that can be forced faulty.
module tb_comp2_arb;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err;
    logic force_bad;
    int   checks = 0;
    int   errors = 0;

    comp2_arb_if bus();

    comp2_arb #(.SETTLE(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    logic [1:0] cx;
    logic [1:0] cy;
    assign cx          = {bus.cmp_x1, bus.cmp_x0};
    assign cy          = {bus.cmp_y1, bus.cmp_y0};
    assign bus.cmp_zx  = force_bad | (cx > cy);
    assign bus.cmp_zy  = force_bad | (cy > cx);
    assign bus.cmp_zeq = ~force_bad & (cx == cy);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready already high; inputs set by the caller.
    task automatic txn(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                       input logic [1:0] ex, input logic [1:0] ey, input logic [2:0] res);
        #1;
        chk({tag, "_grant"}, 8'(bus.req_ready), 8'(gnt));
        tick();
        chk({tag, "_wait_rdy"}, 8'(bus.req_ready), 8'h0);
        chk({tag, "_busy"}, 8'(busy), 8'h1);
        chk({tag, "_early_vld"}, 8'(bus.rsp_valid), 8'h0);
        chk({tag, "_cmp_x"}, 8'(cx), 8'(ex));
        chk({tag, "_cmp_y"}, 8'(cy), 8'(ey));
        tick();
        chk({tag, "_rsp_vld"}, 8'(bus.rsp_valid), 8'h1);
        chk({tag, "_rsp_id"}, 8'(bus.rsp_id), 8'(id));
        chk({tag, "_rsp_res"}, 8'({bus.rsp_zx, bus.rsp_zy, bus.rsp_zeq}), 8'(res));
        chk({tag, "_resp_rdy"}, 8'(bus.req_ready), 8'h0);
        tick();
        chk({tag, "_done_vld"}, 8'(bus.rsp_valid), 8'h0);
        chk({tag, "_done_busy"}, 8'(busy), 8'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        force_bad     = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_x     = 8'h00;
        bus.req_y     = 8'h00;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_vld", 8'(bus.rsp_valid), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_err", 8'(err), 8'h0);
        chk("rst_cmp", 8'({cx, cy}), 8'h0);
        chk("rst_rsp", 8'({bus.rsp_id, bus.rsp_zx, bus.rsp_zy, bus.rsp_zeq}), 8'h0);
        rst = 1'b0;
        #1;
        chk("idle_nogrant", 8'(bus.req_ready), 8'h0);

        // Single request from requester 0: X=1, Y=0.
        bus.req_valid = 4'b0001;
        bus.req_x     = 8'h01;
        bus.req_y     = 8'h00;
        bus.rsp_ready = 1'b1;
        txn("single", 4'b0001, 2'd0, 2'd1, 2'd0, 3'b100);

        // All requesters: X = 3,2,1,0 and Y = 1,1,1,2 for requesters 3..0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_x     = {2'd3, 2'd2, 2'd1, 2'd0};
        bus.req_y     = {2'd1, 2'd1, 2'd1, 2'd2};
        txn("rr0", 4'b0001, 2'd0, 2'd0, 2'd2, 3'b010);
        txn("rr1", 4'b0010, 2'd1, 2'd1, 2'd1, 3'b001);
        txn("rr2", 4'b0100, 2'd2, 2'd2, 2'd1, 3'b100);
        txn("rr3", 4'b1000, 2'd3, 2'd3, 2'd1, 3'b100);
        txn("rr4", 4'b0001, 2'd0, 2'd0, 2'd2, 3'b010);

        // Stalled response from requester 1: X=2, Y=3.
        bus.req_valid = 4'b0010;
        bus.req_x     = {2'd0, 2'd0, 2'd2, 2'd0};
        bus.req_y     = {2'd0, 2'd0, 2'd3, 2'd0};
        bus.rsp_ready = 1'b0;
        #1;
        chk("stall_grant", 8'(bus.req_ready), 8'b0010);
        tick();
        bus.req_valid = 4'b0000;
        bus.req_x     = 8'hFF;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", 8'(bus.rsp_valid), 8'h1);
            chk("stall_fields", 8'({bus.rsp_id, bus.rsp_zx, bus.rsp_zy, bus.rsp_zeq}), 8'b01010);
            chk("stall_rdy", 8'(bus.req_ready), 8'h0);
            chk("stall_busy", 8'(busy), 8'h1);
            chk("stall_cmp", 8'({cx, cy}), 8'b1011);
            tick();
        end
        bus.rsp_ready = 1'b1;
        chk("stall_last_vld", 8'(bus.rsp_valid), 8'h1);
        tick();
        chk("stall_done_vld", 8'(bus.rsp_valid), 8'h0);
        chk("stall_done_busy", 8'(busy), 8'h0);

        // Reset during RESP with requester 2 pending; last grant is requester 1.
        bus.req_valid = 4'b0010;
        bus.req_x     = {2'd0, 2'd1, 2'd0, 2'd0};
        bus.req_y     = {2'd0, 2'd0, 2'd0, 2'd0};
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 4'b0100;
        tick();
        chk("pre_rst_vld", 8'(bus.rsp_valid), 8'h1);
        rst = 1'b1;
        tick();
        chk("rst_resp_vld", 8'(bus.rsp_valid), 8'h0);
        chk("rst_resp_busy", 8'(busy), 8'h0);
        rst = 1'b0;
        bus.req_valid = 4'b0101;
        #1;
        chk("rst_ptr_0101", 8'(bus.req_ready), 8'b0001);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        txn("rst_ptr_0100", 4'b0100, 2'd2, 2'd1, 2'd0, 3'b100);
        bus.req_valid = 4'b0101;
        bus.req_x     = {2'd0, 2'd1, 2'd0, 2'd2};
        bus.req_y     = {2'd0, 2'd0, 2'd0, 2'd1};
        txn("after_2", 4'b0001, 2'd0, 2'd2, 2'd1, 3'b100);

        // Equal operands on requester 3.
        bus.req_valid = 4'b1000;
        bus.req_x     = 8'hC0;
        bus.req_y     = 8'hC0;
        txn("equal", 4'b1000, 2'd3, 2'd3, 2'd3, 3'b001);
        chk("equal_err", 8'(err), 8'h0);

        // Faulty comparator drives zx and zy together.
        force_bad     = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_x     = 8'h01;
        bus.req_y     = 8'h00;
        txn("bad", 4'b0001, 2'd0, 2'd1, 2'd0, 3'b110);
        chk("bad_err", 8'(err), 8'h1);
        force_bad     = 1'b0;
        bus.req_valid = 4'b0010;
        bus.req_x     = 8'h00;
        bus.req_y     = 8'h04;
        txn("good_after", 4'b0010, 2'd1, 2'd0, 2'd1, 3'b010);
        chk("err_sticky", 8'(err), 8'h1);
        bus.req_valid = 4'b0000;
        tick();
        chk("err_sticky_idle", 8'(err), 8'h1);
        rst = 1'b1;
        tick();
        chk("err_clear", 8'(err), 8'h0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
